// File: rtl/io_pkg.sv
// Shared I/O-window word selects (addr[7:2]) and sizing for the CPU I/O port blocks.
package io_pkg;

    localparam int NPORT = 3;
    localparam int OVR_W = 8;

    localparam logic [5:0] IO_OUT0 = 6'b100000;
    localparam logic [5:0] IO_OUT1 = 6'b100001;
    localparam logic [5:0] IO_OUT2 = 6'b100010;
    localparam logic [5:0] IO_SET0 = 6'b100100;
    localparam logic [5:0] IO_CLR0 = 6'b100101;
    localparam logic [5:0] IO_TGL0 = 6'b100110;
    localparam logic [5:0] IO_STAT = 6'b100111;
    localparam logic [5:0] IO_OVR  = 6'b101000;

    // Owned by the input-port block; listed here so both blocks share one address map.
    localparam logic [5:0] IO_IN0  = 6'b110000;
    localparam logic [5:0] IO_IN1  = 6'b110001;

endpackage

// File: rtl/io_output_mux.sv
// Combinational read-back selector for the output-port block.
module io_output_mux #(
    parameter int NPORT = 3,
    parameter int OVR_W = 8
) (
    input  logic [5:0]       sel,
    input  logic [31:0]      port0,
    input  logic [31:0]      port1,
    input  logic [31:0]      port2,
    input  logic [NPORT-1:0] valid,
    input  logic [OVR_W-1:0] ovr,
    output logic [31:0]      rdata
);
    import io_pkg::*;

    always_comb begin
        rdata = '0;
        case (sel)
            IO_OUT0: rdata = port0;
            IO_OUT1: rdata = port1;
            IO_OUT2: rdata = port2;
            IO_STAT: rdata = 32'(valid);
            IO_OVR:  rdata = 32'(ovr);
            // Input-port words are answered by the input block, not here.
            IO_IN0, IO_IN1: rdata = '0;
            default: rdata = '0;
        endcase
    end

endmodule

// File: rtl/io_output_reg.sv
// Memory-mapped output ports with set/clear/toggle aliases on port 0,
// per-port valid/ack handshake and a shared saturating overrun counter.
module io_output_reg #(
    parameter int NPORT = 3,
    parameter int OVR_W = 8
) (
    input  logic             io_clk,
    input  logic             clrn,
    input  logic [31:0]      addr,
    input  logic [31:0]      datain,
    input  logic             write_io_enable,
    input  logic [NPORT-1:0] out_ack,
    output logic [31:0]      out_port0,
    output logic [31:0]      out_port1,
    output logic [31:0]      out_port2,
    output logic [NPORT-1:0] out_valid,
    output logic [31:0]      io_read_data
);
    import io_pkg::*;

    logic [5:0]             sel;
    logic [NPORT-1:0][31:0] port_q, port_d;
    logic [NPORT-1:0]       valid_q, valid_d;
    logic [NPORT-1:0]       hit;
    logic [OVR_W-1:0]       ovr_q, ovr_d;
    logic                   ovr_clr;
    logic                   unused_addr_bits;

    function automatic logic [OVR_W-1:0] sat_inc(input logic [OVR_W-1:0] v);
        return (&v) ? v : v + OVR_W'(1);
    endfunction

    assign sel              = addr[7:2];
    assign unused_addr_bits = ^{addr[31:8], addr[1:0]};

    always_comb begin
        port_d  = port_q;
        hit     = '0;
        ovr_clr = 1'b0;
        if (write_io_enable) begin
            case (sel)
                IO_OUT0: begin port_d[0] = datain;                hit[0] = 1'b1; end
                IO_OUT1: begin port_d[1] = datain;                hit[1] = 1'b1; end
                IO_OUT2: begin port_d[2] = datain;                hit[2] = 1'b1; end
                IO_SET0: begin port_d[0] = port_q[0] | datain;    hit[0] = 1'b1; end
                IO_CLR0: begin port_d[0] = port_q[0] & ~datain;   hit[0] = 1'b1; end
                IO_TGL0: begin port_d[0] = port_q[0] ^ datain;    hit[0] = 1'b1; end
                IO_OVR:  ovr_clr = 1'b1;
                default: ;
            endcase
        end
        // A store beats a same-cycle ack, so the flag stays up.
        valid_d = hit | (valid_q & ~out_ack);
        if (ovr_clr)
            ovr_d = '0;
        else if (|(hit & valid_q & ~out_ack))
            ovr_d = sat_inc(ovr_q);
        else
            ovr_d = ovr_q;
    end

    always_ff @(posedge io_clk or negedge clrn) begin
        if (!clrn) begin
            port_q  <= '0;
            valid_q <= '0;
            ovr_q   <= '0;
        end else begin
            port_q  <= port_d;
            valid_q <= valid_d;
            ovr_q   <= ovr_d;
        end
    end

    assign out_port0 = port_q[0];
    assign out_port1 = port_q[1];
    assign out_port2 = port_q[2];
    assign out_valid = valid_q;

    io_output_mux #(
        .NPORT (NPORT),
        .OVR_W (OVR_W)
    ) u_mux (
        .sel   (sel),
        .port0 (port_q[0]),
        .port1 (port_q[1]),
        .port2 (port_q[2]),
        .valid (valid_q),
        .ovr   (ovr_q),
        .rdata (io_read_data)
    );

endmodule
